vend_credit_controller: RTL

//  Sequences one vending transaction: accepts coin pulses, accumulates credit, and drives the product dispenser via a req/ack handshake.

---
 rtl/vend_pkg.sv | 16 +
 rtl/vend_coin_decode.sv | 37 +++
 rtl/vend_credit_checker.sv | 22 ++
 rtl/vend_credit_controller.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types and coin values for the vending credit controller.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VEND   = 2'd1,
    CHANGE = 2'd2
  } state_t;

  // Coin values in nickel units.
  localparam int          UNITS_W   = 3;
  localparam logic [2:0]  NICKEL_U  = 3'd1;
  localparam logic [2:0]  DIME_U    = 3'd2;
  localparam logic [2:0]  QUARTER_U = 3'd5;

endpackage

// File: rtl/vend_coin_decode.sv
// Combinational coin-pulse decoder: classifies the N/D/Q pulses and
// returns the coin value when exactly one line is high.
module vend_coin_decode
  import vend_pkg::*;
(
  input  logic               N,
  input  logic               D,
  input  logic               Q,
  output logic               valid,
  output logic               multi_hot,
  output logic [UNITS_W-1:0] units
);

  // Map a single active coin line to its value; anything else is worth nothing.
  always_comb begin
    multi_hot = (N & D) | (N & Q) | (D & Q);
    case ({N, D, Q})
      3'b100: begin
        valid = 1'b1;
        units = NICKEL_U;
      end
      3'b010: begin
        valid = 1'b1;
        units = DIME_U;
      end
      3'b001: begin
        valid = 1'b1;
        units = QUARTER_U;
      end
      default: begin
        valid = 1'b0;
        units = 3'd0;
      end
    endcase
  end

endmodule

// File: rtl/vend_credit_checker.sv
// Property checker for the vending controller outputs. Credit is bounded
// by construction, so no saturation logic exists; this watches that bound.
module vend_credit_checker #(
  parameter int PRICE    = 25,
  parameter int CREDIT_W = 4
) (
  input logic                clk,
  input logic                reset,
  input logic [CREDIT_W-1:0] credit,
  input logic                eject_nickel,
  input logic                eject_dime
);

  localparam logic [CREDIT_W-1:0] CREDIT_MAX = CREDIT_W'(PRICE / 5 + 4);

  a_credit_bound: assert property (@(posedge clk) disable iff (reset)
    credit <= CREDIT_MAX);

  a_one_coin_in_flight: assert property (@(posedge clk) disable iff (reset)
    !(eject_nickel && eject_dime));

endmodule

// File: rtl/vend_credit_controller.sv
// Vending transaction sequencer: accumulates coin credit, runs the
// dispenser req/ack handshake with a timeout, and pays change one coin
// at a time from the dime and nickel tubes.
module vend_credit_controller
  import vend_pkg::*;
#(
  parameter int PRICE        = 25,
  parameter int VEND_TIMEOUT = 255,
  parameter int CREDIT_W     = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                N,
  input  logic                D,
  input  logic                Q,
  input  logic                vend_ack,
  input  logic                coin_ack,
  input  logic                nickel_empty,
  input  logic                dime_empty,
  output logic                vend_req,
  output logic                eject_nickel,
  output logic                eject_dime,
  output logic                coin_reject,
  output logic                vend_fail,
  output logic                change_err,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit
);

  localparam int                  PRICE_U  = PRICE / 5;
  localparam int                  CNT_W    = $clog2(VEND_TIMEOUT + 1);
  localparam logic [CREDIT_W-1:0] PRICE_C  = CREDIT_W'(PRICE_U);
  localparam logic [CREDIT_W:0]   PRICE_W  = (CREDIT_W + 1)'(PRICE_U);
  localparam logic [CREDIT_W-1:0] ONE_C    = CREDIT_W'(1);
  localparam logic [CREDIT_W-1:0] TWO_C    = CREDIT_W'(2);
  localparam logic [CREDIT_W-1:0] ZERO_C   = CREDIT_W'(0);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(VEND_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);

  state_t                state_q, state_d;
  logic [CREDIT_W-1:0]   credit_q, credit_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  vend_req_q, vend_req_d;
  logic                  eject_nickel_q, eject_nickel_d;
  logic                  eject_dime_q, eject_dime_d;
  logic                  coin_reject_q, coin_reject_d;
  logic                  vend_fail_q, vend_fail_d;
  logic                  change_err_q, change_err_d;
  logic                  busy_q, busy_d;

  logic                  coin_valid_s;
  logic                  coin_multi_s;
  logic [UNITS_W-1:0]    coin_units_s;
  logic [CREDIT_W:0]     sum_s;
  logic [CREDIT_W:0]     after_vend_s;

  vend_coin_decode u_decode (
    .N         (N),
    .D         (D),
    .Q         (Q),
    .valid     (coin_valid_s),
    .multi_hot (coin_multi_s),
    .units     (coin_units_s)
  );

  // Credit after the incoming coin, one bit wider so the price test cannot wrap.
  always_comb begin
    sum_s        = {1'b0, credit_q} + (CREDIT_W + 1)'(coin_units_s);
    after_vend_s = sum_s - PRICE_W;
  end

  // Next-state and next-output decode for the whole transaction.
  always_comb begin
    state_d        = state_q;
    credit_d       = credit_q;
    cnt_d          = cnt_q;
    vend_req_d     = vend_req_q;
    eject_nickel_d = eject_nickel_q;
    eject_dime_d   = eject_dime_q;
    change_err_d   = change_err_q;
    vend_fail_d    = 1'b0;
    // Coins are only accepted while idle; anything else goes to the chute.
    coin_reject_d  = coin_multi_s | (coin_valid_s & (state_q != IDLE));

    case (state_q)
      IDLE: begin
        if (coin_valid_s) begin
          change_err_d = 1'b0;
          if (sum_s >= PRICE_W) begin
            credit_d   = after_vend_s[CREDIT_W-1:0];
            vend_req_d = 1'b1;
            cnt_d      = '0;
            state_d    = VEND;
          end else begin
            credit_d = sum_s[CREDIT_W-1:0];
          end
        end else begin
          credit_d = credit_q;
        end
      end

      VEND: begin
        // An ack in the timeout cycle still counts as a successful vend.
        if (vend_ack) begin
          vend_req_d = 1'b0;
          state_d    = (credit_q != ZERO_C) ? CHANGE : IDLE;
        end else if (cnt_q == CNT_LAST) begin
          vend_req_d  = 1'b0;
          vend_fail_d = 1'b1;
          credit_d    = credit_q + PRICE_C;
          state_d     = CHANGE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      CHANGE: begin
        // A raised eject is held unchanged until its coin_ack; the low cycle
        // after each ack gives the one-cycle gap between coins.
        if (eject_dime_q) begin
          if (coin_ack) begin
            eject_dime_d = 1'b0;
            credit_d     = credit_q - TWO_C;
            state_d      = (credit_q == TWO_C) ? IDLE : CHANGE;
          end else begin
            eject_dime_d = 1'b1;
          end
        end else if (eject_nickel_q) begin
          if (coin_ack) begin
            eject_nickel_d = 1'b0;
            credit_d       = credit_q - ONE_C;
            state_d        = (credit_q == ONE_C) ? IDLE : CHANGE;
          end else begin
            eject_nickel_d = 1'b1;
          end
        end else if (credit_q == ZERO_C) begin
          state_d = IDLE;
        end else if ((credit_q >= TWO_C) && !dime_empty) begin
          eject_dime_d = 1'b1;
        end else if (!nickel_empty) begin
          eject_nickel_d = 1'b1;
        end else begin
          // Owed credit stays on the display and can be spent on the next item.
          change_err_d = 1'b1;
          state_d      = IDLE;
        end
      end

      default: begin
        state_d        = IDLE;
        vend_req_d     = 1'b0;
        eject_nickel_d = 1'b0;
        eject_dime_d   = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset abandons any transaction in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      credit_q       <= '0;
      cnt_q          <= '0;
      vend_req_q     <= 1'b0;
      eject_nickel_q <= 1'b0;
      eject_dime_q   <= 1'b0;
      coin_reject_q  <= 1'b0;
      vend_fail_q    <= 1'b0;
      change_err_q   <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      cnt_q          <= cnt_d;
      vend_req_q     <= vend_req_d;
      eject_nickel_q <= eject_nickel_d;
      eject_dime_q   <= eject_dime_d;
      coin_reject_q  <= coin_reject_d;
      vend_fail_q    <= vend_fail_d;
      change_err_q   <= change_err_d;
      busy_q         <= busy_d;
    end
  end

  assign vend_req     = vend_req_q;
  assign eject_nickel = eject_nickel_q;
  assign eject_dime   = eject_dime_q;
  assign coin_reject  = coin_reject_q;
  assign vend_fail    = vend_fail_q;
  assign change_err   = change_err_q;
  assign busy         = busy_q;
  assign credit       = credit_q;

endmodule
